// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential/redirected ROM reads and buffers returned words in a FIFO.
// Optional macro FETCH_ALIGN_CHECK_EN: forces redirect targets word-aligned and raises a sticky align_err_out.
module fetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(32'h0040_0000),
   parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'h0000_0004),
   parameter int                DEPTH    = 4
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr_out,
   input  logic [DATA_W-1:0] imem_data_in,
   input  logic              redirect_in,
   input  logic [ADDR_W-1:0] redirect_pc_in,
   output logic              instr_valid_out,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              instr_ready_in,
   output logic              align_err_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W+1)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              inflight_q, inflight_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
   logic [DATA_W-1:0] instr_mem_q [DEPTH];

   logic [ADDR_W-1:0] target;
   logic [CNT_W:0]    occupancy;
   logic              issue, push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
   logic align_err_q;
   logic misaligned;

   assign misaligned = |redirect_pc_in[1:0];
   assign target     = {redirect_pc_in[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clock) begin
      if (reset)
         align_err_q <= 1'b0;
      else if (redirect_in && misaligned)
         align_err_q <= 1'b1;
   end

   assign align_err_out = align_err_q;
`else
   assign target        = redirect_pc_in;
   assign align_err_out = 1'b0;
`endif

   // Words already in flight reserve a slot, so an issue can never overflow the FIFO.
   assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
   assign issue     = redirect_in | (occupancy < DEPTH_OCC);
   assign push      = inflight_q & ~redirect_in;
   assign pop       = (count_q != '0) & instr_ready_in & ~redirect_in;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      if (redirect_in) begin
         fetch_pc_d    = target + PC_STEP;
         inflight_d    = 1'b1;
         inflight_pc_d = target;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         count_d       = '0;
      end else begin
         if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
         end
         if (push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q    <= PC_RESET;
         inflight_q    <= 1'b0;
         inflight_pc_q <= PC_RESET;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Storage needs no reset: count_q gates visibility of every entry.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_data_in;
      end
   end

   assign imem_addr_out   = reset ? PC_RESET : (redirect_in ? target : fetch_pc_q);
   assign instr_valid_out = (count_q != '0);
   assign instr_out       = instr_mem_q[rd_ptr_q];
   assign pc_out          = pc_mem_q[rd_ptr_q];

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter ADDR_W, default 32, SHALL set the PC and instruction-memory address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the instruction width.
REQ-004 Parameter PC_RESET, default 32'h0040_0000, SHALL set the first fetch address after reset.
REQ-005 Parameter PC_STEP, default 32'h0000_0004, SHALL set the sequential PC increment.
REQ-006 Parameter DEPTH, default 4, SHALL set the queue entry count; it is a power of 2 and at least 2.
REQ-007 clock  input  1  rising-edge clock.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 imem_addr_out  output  ADDR_W  instruction ROM address; the ROM returns its word on imem_data_in one cycle later.
REQ-010 imem_data_in  input  DATA_W  ROM data for the address presented in the previous cycle.
REQ-011 redirect_in  input  1  branch/jump taken; flushes the queue and restarts fetch.
REQ-012 redirect_pc_in  input  ADDR_W  target address for the redirect.
REQ-013 instr_valid_out  output  1  queue head is valid.
REQ-014 instr_out  output  DATA_W  instruction at the queue head.
REQ-015 pc_out  output  ADDR_W  PC of instr_out.
REQ-016 instr_ready_in  input  1  consumer accepts the head; a pop occurs when instr_valid_out and instr_ready_in are both 1.
REQ-017 align_err_out  output  1  sticky misaligned-redirect flag; the port is always present.

Function
REQ-018 Registers: fetch_pc, inflight (1 bit), inflight_pc, and a DEPTH-entry FIFO of {pc, instr} with a count of width log2(DEPTH)+1.
REQ-019 An issue SHALL occur in a cycle when redirect_in=1, or when count+inflight<DEPTH; otherwise no issue occurs.
REQ-020 On a sequential issue, imem_addr_out=fetch_pc and fetch_pc<=fetch_pc+PC_STEP; inflight<=1; inflight_pc<=the issued address.
REQ-021 On a redirect, imem_addr_out=redirect_pc_in (after the alignment rule), fetch_pc<=target+PC_STEP, inflight<=1, and inflight_pc<=target.
REQ-022 With no issue, imem_addr_out SHALL hold fetch_pc and inflight<=0.
REQ-023 When inflight=1 and redirect_in=0, {inflight_pc, imem_data_in} SHALL be pushed into the FIFO at that edge.
REQ-024 When redirect_in=1, the word returned that cycle SHALL be discarded, the FIFO SHALL be emptied (count<=0, pointers reset), and any pop SHALL be ignored.
REQ-025 instr_valid_out SHALL equal (count!=0); instr_out and pc_out SHALL come from the head entry; there is no bypass.
REQ-026 Latency SHALL be 2 cycles from issue to instr_valid_out.
REQ-027 With ready=1 and DEPTH>=3, the queue SHALL deliver one instruction per cycle in steady state.
REQ-028 A push and a pop in the same cycle SHALL leave count unchanged; the FIFO SHALL never overflow or underflow.
REQ-029 PC arithmetic SHALL be modulo 2^ADDR_W, and FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 Entries SHALL leave the queue in issue order, with no duplicates or drops, except entries removed by a flush.

Reset
REQ-031 On reset: fetch_pc=PC_RESET, inflight=0, count=0, pointers=0, instr_valid_out=0, align_err_out=0, and imem_addr_out=PC_RESET.
REQ-032 A reset in mid-operation SHALL discard every queued and in-flight word.
REQ-033 Reset SHALL take priority over redirect_in.
REQ-034 The first issue, at PC_RESET, SHALL occur in the first cycle with reset=0.

Configuration
REQ-035 With macro FETCH_ALIGN_CHECK_EN defined, a redirect with redirect_pc_in[1:0]!=0 SHALL use the target with bits [1:0] forced to 0, and SHALL set align_err_out=1 until reset.
REQ-036 With FETCH_ALIGN_CHECK_EN undefined, redirect_pc_in SHALL be used unmodified and align_err_out SHALL be tied to 0.

Verification
REQ-037 Release reset with ready=1 -> imem_addr_out=0x00400000 in cycle 0; instr_valid_out=1 with pc_out=0x00400000 in cycle 2; pc_out then increments by 4 every cycle.
REQ-038 Hold ready=0 after reset -> exactly 4 issues (0x00400000..0x0040000C) and count=4; then raise ready -> those 4 entries are delivered in order, followed by 0x00400010.
REQ-039 Redirect to 0x00400100 with 3 entries queued -> instr_valid_out=0 the next cycle; pc_out=0x00400100 two cycles after the redirect; no stale PC is ever delivered.
REQ-040 Redirect coinciding with a pop and an arriving word -> the pop is ignored, the word is dropped, and the first delivered PC is the target.
REQ-041 Redirect to 0xFFFFFFFC -> delivered PCs are 0xFFFFFFFC, then 0x00000000.
REQ-042 Redirect to 0x00400102 -> with the macro: pc_out=0x00400100 and align_err_out stays 1 until reset; without the macro: pc_out=0x00400102 and align_err_out=0.
